cmd_reply: RTL and testbench

- Transmit-side counterpart of the command key matcher.
- On a start request, formats one reply packet for the UART transmitter: `KEY` byte, then the captured data word as uppercase ASCII hex (MSB nibble first), then line feed (10).
- The packet framing is exactly what the command parser on the far end accepts.
- Sits between controller logic (laser state/status) and the UART TX byte interface.

---
 rtl/cmd_reply.sv | 121 ++++++++++++
 tb/tb_cmd_reply.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_reply.sv
// Reply packet formatter: emits KEY, the captured word as uppercase ASCII hex
// (most significant nibble first), then a line feed, over a valid/ready byte link.
module cmd_reply #(
  parameter logic [7:0] KEY    = "a",
  parameter int         DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  input  logic              tx_ready,
  output logic              done,
  output logic [1:0]        dbg_state
);

  // Handshake: a byte moves on a clk edge where out_valid & tx_ready; while
  // out_valid is high and tx_ready is low, out_byte holds its value, and
  // out_valid stays high from the KEY byte through the line feed.

  localparam int         NIBBLES  = DATA_W / 4;
  localparam logic [3:0] LAST_NIB = 4'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_KEY, S_HEX, S_EOL} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [3:0]        nib_q, nib_d;
  logic [7:0]        byte_q, byte_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              xfer;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign xfer = valid_q & tx_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    nib_d   = nib_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_KEY;
          data_d  = data;
          nib_d   = '0;
          byte_d  = KEY;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_KEY: begin
        // The word is shifted left so the next nibble is always at the top.
        if (xfer) begin
          state_d = S_HEX;
          byte_d  = hex_char(data_q[DATA_W-1 -: 4]);
          data_d  = data_q << 4;
          nib_d   = '0;
        end
      end
      S_HEX: begin
        if (xfer) begin
          if (nib_q == LAST_NIB) begin
            state_d = S_EOL;
            byte_d  = 8'h0A;
          end else begin
            nib_d  = nib_q + 4'd1;
            byte_d = hex_char(data_q[DATA_W-1 -: 4]);
            data_d = data_q << 4;
          end
        end
      end
      S_EOL: begin
        if (xfer) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      nib_q   <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      nib_q   <= nib_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign out_byte  = byte_q;
  assign out_valid = valid_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cmd_reply.sv
// Directed bench for cmd_reply: default 16-bit "a" instance plus an 8-bit "z" instance.
module tb_cmd_reply;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] data;
  logic        busy;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        tx_ready;
  logic        done;
  logic [1:0]  dbg_state;

  logic        start8;
  logic [7:0]  data8;
  logic        busy8;
  logic [7:0]  out_byte8;
  logic        out_valid8;
  logic        tx_ready8;
  logic        done8;
  logic [1:0]  dbg_state8;

  int n_checks;
  int n_fail;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         stall_changes;
  int         first_valid_cyc;
  bit         timed_out;

  cmd_reply #(.KEY("a"), .DATA_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data(data), .busy(busy),
    .out_byte(out_byte), .out_valid(out_valid), .tx_ready(tx_ready),
    .done(done), .dbg_state(dbg_state)
  );

  cmd_reply #(.KEY("z"), .DATA_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .data(data8), .busy(busy8),
    .out_byte(out_byte8), .out_valid(out_valid8), .tx_ready(tx_ready8),
    .done(done8), .dbg_state(dbg_state8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one packet and records every transferred byte into got_q.
  // mode 0: tx_ready high; mode 1: tx_ready 1,0,0 repeating;
  // mode 2: tx_ready high, extra start and new data mid-packet.
  // Returns at the negedge where done is seen (or on budget expiry).
  task automatic run_packet(input logic [15:0] d, input int mode, input bit in_done_cycle);
    logic [7:0] held;
    bit         held_v;
    int         cyc;
    got_q.delete();
    stall_changes   = 0;
    first_valid_cyc = -1;
    timed_out       = 1'b0;
    held_v          = 1'b0;
    held            = 8'h00;
    if (!in_done_cycle) @(negedge clk);
    start    = 1'b1;
    data     = d;
    tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    data  = ~d;
    cyc   = 0;
    while (!done && cyc < 200) begin
      start    = (mode == 2 && cyc == 2) ? 1'b1 : 1'b0;
      data     = (mode == 2) ? (d ^ 16'h5A5A) : ~d;
      tx_ready = (mode == 1) ? ((cyc % 3) == 0) : 1'b1;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (held_v && out_byte !== held) stall_changes++;
      if (out_valid && tx_ready) begin
        got_q.push_back(out_byte);
        held_v = 1'b0;
      end else if (out_valid) begin
        held   = out_byte;
        held_v = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    timed_out = (cyc >= 200);
    start     = 1'b0;
    tx_ready  = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; data = '0; tx_ready = 1'b0;
    start8 = 1'b0; data8 = '0; tx_ready8 = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_byte !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b busy=%b done=%b byte=%h, want 0 0 0 00",
               out_valid, busy, done, out_byte);
    end
    n_checks++;
    if (dbg_state !== 2'd0 || dbg_state8 !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d state8=%0d, want 0 0", dbg_state, dbg_state8);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_valid8 !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: valid=%b busy=%b valid8=%b, want 0 0 0",
               out_valid, busy, out_valid8);
    end
  endtask

  task automatic test_basic_timing();
    @(negedge clk);
    start = 1'b1; data = 16'h1F3C; tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; data = 16'h0000;
    exp_q = {8'h61, 8'h31, 8'h46, 8'h33, 8'h43, 8'h0A};
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || out_byte !== exp_q[i]) begin
        n_fail++;
        $display("FAIL basic_byte%0d: valid=%b busy=%b done=%b byte=%h, want 1 1 0 %h",
                 i, out_valid, busy, done, out_byte, exp_q[i]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: done=%b valid=%b busy=%b, want 1 0 0", done, out_valid, busy);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_pulse: done=%b valid=%b, want 0 0", done, out_valid);
    end
  endtask

  task automatic test_backpressure();
    run_packet(16'h1F3C, 1, 1'b0);
    exp_q = {8'h61, 8'h31, 8'h46, 8'h33, 8'h43, 8'h0A};
    n_checks++;
    if (timed_out || got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL stall_count: got %0d bytes timeout=%b, want %0d bytes",
               got_q.size(), timed_out, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL stall_byte%0d: got %h, want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    n_checks++;
    if (stall_changes != 0) begin
      n_fail++;
      $display("FAIL stall_stable: out_byte changed %0d times while stalled, want 0", stall_changes);
    end
  endtask

  task automatic test_back_to_back();
    run_packet(16'h0000, 0, 1'b0);
    exp_q = {8'h61, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0A};
    n_checks++;
    if (timed_out || got_q != exp_q) begin
      n_fail++;
      $display("FAIL b2b_first: got %p timeout=%b, want %p", got_q, timed_out, exp_q);
    end
    run_packet(16'hFFFF, 0, 1'b1);
    exp_q = {8'h61, 8'h46, 8'h46, 8'h46, 8'h46, 8'h0A};
    n_checks++;
    if (timed_out || got_q != exp_q) begin
      n_fail++;
      $display("FAIL b2b_second: got %p timeout=%b, want %p", got_q, timed_out, exp_q);
    end
    n_checks++;
    if (first_valid_cyc != 0) begin
      n_fail++;
      $display("FAIL b2b_gap: first valid at cycle %0d after start, want 0", first_valid_cyc);
    end
  endtask

  task automatic test_ignore_start();
    int extra;
    run_packet(16'hBEEF, 2, 1'b0);
    exp_q = {8'h61, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0A};
    n_checks++;
    if (timed_out || got_q != exp_q) begin
      n_fail++;
      $display("FAIL ignore_packet: got %p timeout=%b, want %p", got_q, timed_out, exp_q);
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL ignore_queued: %0d busy/valid cycles after done, want 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    @(negedge clk);
    start = 1'b1; data = 16'h1F3C; tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_byte !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b busy=%b done=%b byte=%h, want 0 0 0 00",
               out_valid, busy, done, out_byte);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      tx_ready = (i % 2) == 0;
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL reset_no_resume: %0d active cycles after release, want 0", stray);
    end
    tx_ready = 1'b1;
  endtask

  task automatic test_narrow();
    @(negedge clk);
    start8 = 1'b1; data8 = 8'hA5; tx_ready8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; data8 = 8'h00;
    exp_q = {8'h7A, 8'h41, 8'h35, 8'h0A};
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid8 !== 1'b1 || out_byte8 !== exp_q[i]) begin
        n_fail++;
        $display("FAIL narrow_byte%0d: valid=%b byte=%h, want 1 %h", i, out_valid8, out_byte8, exp_q[i]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (done8 !== 1'b1 || out_valid8 !== 1'b0 || busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL narrow_done: done=%b valid=%b busy=%b, want 1 0 0", done8, out_valid8, busy8);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic_timing();
    test_backpressure();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_narrow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
